// File: rtl/fir_drv_if.sv
// Control, stream, result and FIR-core signals of fir_drv.
// The driver uses the slave view; the host/core side uses the master view.
interface fir_drv_if #(
    parameter int unsigned BW_in  = 6,
    parameter int unsigned BW_out = 8
) ();
    logic                     cfg_we;
    logic [2:0]               cfg_addr;
    logic signed [BW_in-1:0]  cfg_data;
    logic                     start;
    logic                     stop;
    logic                     busy;
    logic                     s_valid;
    logic                     s_ready;
    logic signed [BW_in-1:0]  s_data;
    logic                     r_valid;
    logic [BW_out-1:0]        r_data;
    logic                     underrun;
    logic                     fir_reset;
    logic signed [BW_in-1:0]  fir_x_in;
    logic [BW_out-1:0]        fir_y_out;

    modport master (
        output cfg_we, cfg_addr, cfg_data, start, stop, s_valid, s_data, fir_y_out,
        input  busy, s_ready, r_valid, r_data, underrun, fir_reset, fir_x_in
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, start, stop, s_valid, s_data, fir_y_out,
        output busy, s_ready, r_valid, r_data, underrun, fir_reset, fir_x_in
    );
endinterface

// File: rtl/fir_drv.sv
// Host-side driver for a serial-load FIR core: coefficient table, reset/load sequencing,
// sample streaming and tagged result capture. FIR_DRV_HOLD_EN repeats the last sample on underrun.
module fir_drv #(
    parameter int unsigned N_TAPS     = 7,
    parameter int unsigned BW_in      = 6,
    parameter int unsigned BW_out     = 8,
    parameter int unsigned RST_CYCLES = 2
) (
    input logic      clk,
    input logic      reset,
    fir_drv_if.slave bus
);
    localparam int unsigned CntMax = (RST_CYCLES > N_TAPS) ? RST_CYCLES : N_TAPS;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam int unsigned AddrW  = $clog2(N_TAPS);

    typedef enum logic [1:0] {StIdle, StRst, StLoad, StStream} state_e;

    state_e                  state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic signed [BW_in-1:0] table_q [N_TAPS];
    logic                    tbl_we;
    logic                    fir_reset_q, fir_reset_d;
    logic signed [BW_in-1:0] fir_x_q, fir_x_d;
    // Tag pipeline aligns the "real sample" flag with the core's 3-cycle result latency.
    logic [2:0]              tag_q, tag_d;
    logic                    r_valid_q, r_valid_d;
    logic [BW_out-1:0]       r_data_q, r_data_d;
    logic                    underrun_q, underrun_d;
    logic [AddrW-1:0]        load_idx;
`ifdef FIR_DRV_HOLD_EN
    logic signed [BW_in-1:0] hold_q, hold_d;
`endif

    // Next coefficient to present: highest index first, so table[k] ends in core tap k.
    assign load_idx = AddrW'(N_TAPS - 2 - 32'(cnt_q));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tbl_we      = 1'b0;
        fir_reset_d = fir_reset_q;
        fir_x_d     = fir_x_q;
        tag_d       = {tag_q[1:0], 1'b0};
        r_valid_d   = tag_q[2];
        r_data_d    = bus.fir_y_out;
        underrun_d  = underrun_q;
`ifdef FIR_DRV_HOLD_EN
        hold_d      = hold_q;
`endif
        unique case (state_q)
            StIdle: begin
                fir_reset_d = 1'b1;
                fir_x_d     = '0;
                tbl_we      = bus.cfg_we && (32'(bus.cfg_addr) < N_TAPS);
                if (bus.start) begin
                    state_d    = StRst;
                    cnt_d      = '0;
                    underrun_d = 1'b0;
`ifdef FIR_DRV_HOLD_EN
                    hold_d     = '0;
`endif
                end
            end
            StRst: begin
                if (cnt_q == CntW'(RST_CYCLES - 1)) begin
                    state_d     = StLoad;
                    cnt_d       = '0;
                    fir_reset_d = 1'b0;
                    fir_x_d     = table_q[N_TAPS-1];
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StLoad: begin
                if (cnt_q == CntW'(N_TAPS - 1)) begin
                    state_d = StStream;
                    fir_x_d = '0;
                end else begin
                    fir_x_d = table_q[load_idx];
                    cnt_d   = cnt_q + CntW'(1);
                end
            end
            StStream: begin
                if (!bus.s_valid) underrun_d = 1'b1;
                if (bus.stop) begin
                    state_d     = StIdle;
                    fir_reset_d = 1'b1;
                    fir_x_d     = '0;
                    tag_d       = '0;
                    r_valid_d   = 1'b0;
                end else if (bus.s_valid) begin
                    fir_x_d  = bus.s_data;
                    tag_d[0] = 1'b1;
`ifdef FIR_DRV_HOLD_EN
                    hold_d   = bus.s_data;
`endif
                end else begin
`ifdef FIR_DRV_HOLD_EN
                    fir_x_d = hold_q;
`else
                    fir_x_d = '0;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            fir_reset_q <= 1'b1;
            fir_x_q     <= '0;
            tag_q       <= '0;
            r_valid_q   <= 1'b0;
            r_data_q    <= '0;
            underrun_q  <= 1'b0;
            for (int unsigned k = 0; k < N_TAPS; k++) table_q[k] <= '0;
`ifdef FIR_DRV_HOLD_EN
            hold_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fir_reset_q <= fir_reset_d;
            fir_x_q     <= fir_x_d;
            tag_q       <= tag_d;
            r_valid_q   <= r_valid_d;
            r_data_q    <= r_data_d;
            underrun_q  <= underrun_d;
            if (tbl_we) table_q[bus.cfg_addr] <= bus.cfg_data;
`ifdef FIR_DRV_HOLD_EN
            hold_q      <= hold_d;
`endif
        end
    end

    assign bus.busy      = (state_q != StIdle);
    assign bus.s_ready   = (state_q == StStream);
    assign bus.r_valid   = r_valid_q;
    assign bus.r_data    = r_data_q;
    assign bus.underrun  = underrun_q;
    assign bus.fir_reset = fir_reset_q;
    assign bus.fir_x_in  = fir_x_q;
endmodule

// File: tb/tb_fir_drv.sv
// Bench for fir_drv: behavioural FIR core plus a convolution reference model of expected results.
module tb_fir_drv;
    localparam int NT = 7;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fir_drv_if #(.BW_in(6), .BW_out(8)) bif ();

    fir_drv #(
        .N_TAPS    (NT),
        .BW_in     (6),
        .BW_out    (8),
        .RST_CYCLES(2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bif.slave)
    );

    // Serial-load core: N taps shifted in after reset, then one sample per clock, y registered.
    logic signed [5:0] core_coef [NT];
    logic signed [5:0] core_x    [NT];
    logic [7:0]        core_y;
    int                core_ld;
    int                core_acc;

    always_comb begin
        core_acc = 0;
        for (int k = 0; k < NT; k++) core_acc += int'(core_coef[k]) * int'(core_x[k]);
    end

    always_ff @(posedge clk) begin
        if (bif.fir_reset) begin
            core_ld <= 0;
            core_y  <= '0;
            for (int k = 0; k < NT; k++) core_x[k] <= '0;
        end else if (core_ld < NT) begin
            core_coef[0] <= bif.fir_x_in;
            for (int k = 1; k < NT; k++) core_coef[k] <= core_coef[k-1];
            core_ld <= core_ld + 1;
        end else begin
            core_x[0] <= bif.fir_x_in;
            for (int k = 1; k < NT; k++) core_x[k] <= core_x[k-1];
            core_y <= 8'(core_acc);
        end
    end
    assign bif.fir_y_out = core_y;

    int n_chk = 0;
    int n_bad = 0;
    int tbl [NT];
    int sv_q [$];
    int sd_q [$];

    task automatic check_eq(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected FIR word for stream slot m: truncated convolution with the table.
    function automatic int exp_out(input int w [$], input int m);
        int acc = 0;
        for (int k = 0; k < NT; k++) if (m - k >= 0) acc += tbl[k] * w[m-k];
        return acc & 255;
    endfunction

    task automatic cfg_write(input int addr, input int data);
        bif.cfg_we   = 1'b1;
        bif.cfg_addr = 3'(addr);
        bif.cfg_data = 6'(data);
        tick();
        bif.cfg_we = 1'b0;
        if (addr < NT) tbl[addr] = data;
    endtask

    task automatic run_start(input bit wr, input int waddr, input int wdata);
        bif.start    = 1'b1;
        bif.cfg_we   = wr;
        bif.cfg_addr = 3'(waddr);
        bif.cfg_data = 6'(wdata);
        if (wr && waddr < NT) tbl[waddr] = wdata;
        tick();
        bif.start  = 1'b0;
        bif.cfg_we = 1'b0;
        check_eq("busy_after_start", int'(bif.busy), 1);
        check_eq("underrun_cleared", int'(bif.underrun), 0);
        for (int c = 0; c < 2; c++) begin
            check_eq("rst_pulse", int'(bif.fir_reset), 1);
            check_eq("s_ready_rst", int'(bif.s_ready), 0);
            tick();
        end
        for (int i = 0; i < NT; i++) begin
            check_eq("load_x", int'(bif.fir_x_in), tbl[NT-1-i]);
            check_eq("load_fir_reset", int'(bif.fir_reset), 0);
            check_eq("s_ready_load", int'(bif.s_ready), 0);
            // Writes, start and stop while loading must all be ignored.
            bif.cfg_we   = 1'($urandom_range(0, 1));
            bif.cfg_addr = 3'($urandom_range(0, 7));
            bif.cfg_data = 6'($urandom_range(0, 63));
            bif.start    = 1'($urandom_range(0, 1));
            bif.stop     = 1'($urandom_range(0, 1));
            tick();
        end
        bif.cfg_we = 1'b0;
        bif.start  = 1'b0;
        bif.stop   = 1'b0;
        check_eq("s_ready_stream", int'(bif.s_ready), 1);
        check_eq("stream_x0", int'(bif.fir_x_in), 0);
    endtask

    // Streams sv_q/sd_q plus three valid pad samples, which are still in flight at stop.
    task automatic stream_run();
        int w [$];
        int tg [$];
        int und  = 0;
        int last = 0;
        int word;
        for (int p = 0; p < 3; p++) begin
            sv_q.push_back(1);
            sd_q.push_back(int'($urandom_range(0, 63)) - 32);
        end
        for (int j = 0; j < sv_q.size(); j++) begin
            bif.s_valid = 1'(sv_q[j]);
            bif.s_data  = 6'(sd_q[j]);
            if (sv_q[j] != 0) begin
                word = sd_q[j];
                last = sd_q[j];
            end else begin
`ifdef FIR_DRV_HOLD_EN
                word = last;
`else
                word = 0;
`endif
                und = 1;
            end
            w.push_back(word);
            tg.push_back(sv_q[j]);
            tick();
            check_eq("underrun", int'(bif.underrun), und);
            if (j >= 3) begin
                check_eq("r_valid", int'(bif.r_valid), tg[j-3]);
                check_eq("r_data", int'(bif.r_data), exp_out(w, j - 3));
            end else begin
                check_eq("r_valid_early", int'(bif.r_valid), 0);
            end
        end
        bif.s_valid = 1'b1;
        bif.s_data  = 6'($urandom_range(0, 63));
        bif.stop    = 1'b1;
        tick();
        bif.stop    = 1'b0;
        bif.s_valid = 1'b0;
        check_eq("stop_busy", int'(bif.busy), 0);
        check_eq("stop_fir_reset", int'(bif.fir_reset), 1);
        check_eq("stop_x", int'(bif.fir_x_in), 0);
        check_eq("stop_s_ready", int'(bif.s_ready), 0);
        for (int c = 0; c < 5; c++) begin
            check_eq("stop_r_valid", int'(bif.r_valid), 0);
            tick();
        end
        check_eq("underrun_sticky", int'(bif.underrun), und);
        sv_q.delete();
        sd_q.delete();
    endtask

    task automatic push(input int v, input int d);
        sv_q.push_back(v);
        sd_q.push_back(d);
    endtask

    initial begin
        bif.cfg_we = 1'b0; bif.cfg_addr = '0; bif.cfg_data = '0;
        bif.start  = 1'b0; bif.stop = 1'b0; bif.s_valid = 1'b0; bif.s_data = '0;
        for (int k = 0; k < NT; k++) tbl[k] = 0;
        tick();
        tick();
        check_eq("rst_busy", int'(bif.busy), 0);
        check_eq("rst_fir_reset", int'(bif.fir_reset), 1);
        check_eq("rst_x", int'(bif.fir_x_in), 0);
        check_eq("rst_r_valid", int'(bif.r_valid), 0);
        check_eq("rst_r_data", int'(bif.r_data), 0);
        check_eq("rst_underrun", int'(bif.underrun), 0);
        check_eq("rst_s_ready", int'(bif.s_ready), 0);
        reset = 1'b0;
        tick();

        // Impulse on tap 0; out-of-range write must be ignored.
        cfg_write(0, 1);
        cfg_write(7, 13);
        run_start(1'b0, 0, 0);
        push(1, 5); push(1, -3); push(1, 7);
        stream_run();

        // Tap ordering, with the table write coinciding with start.
        cfg_write(0, 0);
        run_start(1'b1, 3, 2);
        for (int i = 0; i < 5; i++) push(1, (i == 0) ? 1 : 0);
        stream_run();

        // Truncation: 7 * 31 * 31 = 6727 -> 0x47.
        for (int k = 0; k < NT; k++) cfg_write(k, 31);
        run_start(1'b0, 0, 0);
        for (int i = 0; i < 12; i++) push(1, 31);
        stream_run();

        // Underrun gap.
        for (int k = 0; k < NT; k++) cfg_write(k, (k == 0) ? 1 : 0);
        run_start(1'b0, 0, 0);
        push(1, 1); push(0, 9); push(1, 1);
        stream_run();

        // Randomized tables and streams with occasional gaps.
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < NT; k++) cfg_write(k, int'($urandom_range(0, 63)) - 32);
            run_start(1'b0, 0, 0);
            for (int i = 0; i < 20; i++)
                push(($urandom_range(0, 4) != 0) ? 1 : 0, int'($urandom_range(0, 63)) - 32);
            stream_run();
        end

        // Reset in the middle of LOAD clears everything, including the table.
        for (int k = 0; k < NT; k++) cfg_write(k, k + 1);
        bif.start = 1'b1;
        tick();
        bif.start = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < NT; k++) tbl[k] = 0;
        check_eq("abort_busy", int'(bif.busy), 0);
        check_eq("abort_fir_reset", int'(bif.fir_reset), 1);
        check_eq("abort_x", int'(bif.fir_x_in), 0);
        check_eq("abort_s_ready", int'(bif.s_ready), 0);
        run_start(1'b0, 0, 0);
        push(1, 4); push(1, -8);
        stream_run();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
